sigmoid_rr_scheduler: RTL and testbench

//  Shares one sigmoid_pipelined datapath between N_REQ requesters through round-robin arbitration.
//  - Accepts at most one operand per cycle and drives it into the pipeline.
//  - Carries the requester ID down a tag shift line matched to the pipeline latency.
//  - Routes each result back to its requester on a shared response bus with a one-hot valid.
//  - Sits between the client blocks and sigmoid_pipelined; checks pipeline alignment at run time.

---
 rtl/sigmoid_rr_scheduler_if.sv | 21 ++
 rtl/sigmoid_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_sigmoid_rr_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigmoid_rr_scheduler_if.sv
// Requester-side bundle: operand handshake toward the scheduler and the shared result bus back.
interface sigmoid_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 16
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    resp_valid;
  logic [DW-1:0]       resp_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sigmoid_rr_scheduler.sv
// Round-robin front end sharing one pipelined sigmoid datapath between N_REQ requesters,
// with a requester-ID tag line matched to the datapath latency and a sticky alignment check.
module sigmoid_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 5,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  sigmoid_rr_scheduler_if.slave req_if,
  output logic                  sig_valid_in,
  output logic [DW-1:0]         sig_data_in,
  input  logic                  sig_valid_out,
  input  logic [DW-1:0]         sig_data_out,
  output logic                  busy,
  output logic                  align_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(LATENCY + 3);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_idx;
  logic             w_found;
  logic [N_REQ-1:0] w_grant;
  logic             w_hs;
  logic [DW-1:0]    w_win_data;

  logic             r_sig_valid_in;
  logic [DW-1:0]    r_sig_data_in;
  tag_t             r_tag [0:LATENCY];
  tag_t             w_tag_out;
  logic             w_capture;
  logic             w_mismatch;
  logic             w_drop;

  logic [N_REQ-1:0] r_resp_valid;
  logic [DW-1:0]    r_resp_data;
  logic             r_align_err;
  logic [CW-1:0]    r_cnt;
  logic             w_dec;

  // Search starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_idx = IDW'((32'(r_last) + k) % 32'(N_REQ));
      if (!w_found && req_if.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (rst && enable && w_found) begin
      w_grant[w_winner] = 1'b1;
    end
  end

  assign w_hs             = |w_grant;
  assign w_win_data       = req_if.req_data[w_winner*DW +: DW];
  assign req_if.req_ready = w_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last         <= IDW'(N_REQ - 1);
      r_sig_valid_in <= 1'b0;
      r_sig_data_in  <= '0;
    end else begin
      r_sig_valid_in <= w_hs;
      if (w_hs) begin
        r_last        <= w_winner;
        r_sig_data_in <= w_win_data;
      end
    end
  end

  assign sig_valid_in = r_sig_valid_in;
  assign sig_data_in  = r_sig_data_in;

  // Stage 0 loads alongside sig_valid_in; LATENCY further stages bring the tag out
  // in the same cycle the datapath presents sig_valid_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{v: w_hs, id: w_winner};
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_tag_out  = r_tag[LATENCY];
  assign w_capture  = w_tag_out.v & sig_valid_out;
  assign w_mismatch = w_tag_out.v ^ sig_valid_out;
  assign w_drop     = w_tag_out.v & ~sig_valid_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_align_err  <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      if (w_capture) begin
        r_resp_valid <= N_REQ'(1) << w_tag_out.id;
        r_resp_data  <= sig_data_out;
      end
      if (w_mismatch) begin
        r_align_err <= 1'b1;
      end
    end
  end

  assign req_if.resp_valid = r_resp_valid;
  assign req_if.resp_data  = r_resp_data;
  assign align_err         = r_align_err;

  // Only a lost tagged op retires early; a stray datapath valid owns no count.
  assign w_dec = (|r_resp_valid) | w_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_hs && !w_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_hs && w_dec) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: tb/tb_sigmoid_rr_scheduler.sv
// Bench for sigmoid_rr_scheduler: stub datapath (out = in ^ A5A5, LATENCY cycles), grant vector
// table, scoreboard on the response bus, and hand sequences for drain, alignment and reset.
module tb_sigmoid_rr_scheduler;
  localparam int NR  = 4;
  localparam int LAT = 5;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          sig_valid_in;
  logic [DW-1:0] sig_data_in;
  logic          sig_valid_out;
  logic [DW-1:0] sig_data_out;
  logic          busy;
  logic          align_err;
  logic          inj;

  sigmoid_rr_scheduler_if #(.N_REQ(NR), .DW(DW)) rif ();

  sigmoid_rr_scheduler #(.N_REQ(NR), .LATENCY(LAT), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .req_if        (rif),
    .sig_valid_in  (sig_valid_in),
    .sig_data_in   (sig_data_in),
    .sig_valid_out (sig_valid_out),
    .sig_data_out  (sig_data_out),
    .busy          (busy),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  logic [LAT-1:0] st_v;
  logic [DW-1:0]  st_d [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_v <= '0;
      for (int i = 0; i < LAT; i++) st_d[i] <= '0;
    end else begin
      st_v    <= {st_v[LAT-2:0], sig_valid_in};
      st_d[0] <= sig_data_in ^ 16'hA5A5;
      for (int i = 1; i < LAT; i++) st_d[i] <= st_d[i-1];
    end
  end
  assign sig_valid_out = st_v[LAT-1] | inj;
  assign sig_data_out  = st_d[LAT-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_resp_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    int            c;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    sb_t e;
    logic [NR-1:0] hs;
    if (!rst) begin
      sb.delete();
    end else begin
      hs = rif.req_valid & rif.req_ready;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          e.id = i;
          e.d  = rif.req_data[i*DW +: DW] ^ 16'hA5A5;
          e.c  = cyc;
          sb.push_back(e);
        end
      end
      if (rif.resp_valid != '0) begin
        last_resp_cyc = cyc;
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(rif.resp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("resp_strobe", 32'(rif.resp_valid), 32'(1) << e.id);
          chk("resp_data", 32'(rif.resp_data), 32'(e.d));
          chk("resp_latency", 32'(cyc - e.c), 32'(LAT + 2));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_busy_fall"}, 32'(cyc), 32'(last_resp_cyc + 1));
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 32'(rif.req_ready), 32'h0);
    chk({nm, "_sig_vin"}, 32'(sig_valid_in), 32'h0);
    chk({nm, "_sig_din"}, 32'(sig_data_in), 32'h0);
    chk({nm, "_resp_v"}, 32'(rif.resp_valid), 32'h0);
    chk({nm, "_resp_d"}, 32'(rif.resp_data), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_align"}, 32'(align_err), 32'h0);
  endtask

  typedef struct {
    logic          en;
    logic [NR-1:0] rv;
    logic [NR-1:0] exp;
  } vec_t;
  vec_t vt[16];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b1, 4'b1111, 4'b0001};
    vt[1]  = '{1'b1, 4'b1111, 4'b0010};
    vt[2]  = '{1'b1, 4'b1111, 4'b0100};
    vt[3]  = '{1'b1, 4'b1111, 4'b1000};
    vt[4]  = '{1'b1, 4'b1111, 4'b0001};
    vt[5]  = '{1'b1, 4'b1111, 4'b0010};
    vt[6]  = '{1'b1, 4'b1111, 4'b0100};
    vt[7]  = '{1'b1, 4'b1111, 4'b1000};
    vt[8]  = '{1'b1, 4'b0010, 4'b0010};
    vt[9]  = '{1'b1, 4'b1010, 4'b1000};
    vt[10] = '{1'b1, 4'b1010, 4'b0010};
    vt[11] = '{1'b1, 4'b1010, 4'b1000};
    vt[12] = '{1'b0, 4'b1111, 4'b0000};
    vt[13] = '{1'b1, 4'b0000, 4'b0000};
    vt[14] = '{1'b1, 4'b0101, 4'b0001};
    vt[15] = '{1'b1, 4'b0101, 4'b0100};

    rst           = 1'b0;
    enable        = 1'b0;
    inj           = 1'b0;
    rif.req_valid = '0;
    rif.req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst    = 1'b1;
    enable = 1'b1;

    // single op from requester 0
    step();
    rif.req_valid = 4'b0001;
    rif.req_data  = {48'h0, 16'h0100};
    @(negedge clk);
    chk("t1_ready", 32'(rif.req_ready), 32'h1);
    step();
    rif.req_valid = '0;
    wait_idle("t1");
    chk("t1_resp_hold", 32'(rif.resp_data), 32'hA4A5);

    // fresh pointer, then grant table
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      enable        = vt[i].en;
      rif.req_valid = vt[i].rv;
      rif.req_data  = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(rif.req_ready), 32'(vt[i].exp));
    end
    step();
    enable        = 1'b1;
    rif.req_valid = '0;
    wait_idle("table");

    // enable drops with three ops in flight
    for (int i = 0; i < 3; i++) begin
      step();
      rif.req_valid = 4'b1111;
      rif.req_data  = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("t4_issue%0d", i), 32'(rif.req_ready), 32'(4'b1000) >> (3 - ((i + 3) % 4)));
    end
    step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_ready_off", 32'(rif.req_ready), 32'h0);
      step();
    end
    wait_idle("t4");
    enable        = 1'b1;
    rif.req_valid = '0;

    // stray datapath valid with no tag
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_align", 32'(align_err), 32'h1);
      chk("t5_no_resp", 32'(rif.resp_valid), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
    end

    // reset with four ops in flight
    for (int i = 0; i < 4; i++) begin
      step();
      rif.req_valid = 4'b1111;
      rif.req_data  = {$urandom, $urandom};
    end
    step();
    rst = 1'b0;
    #1;
    chk_reset_outputs("t6");
    rif.req_valid = '0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t6_no_resp", 32'(rif.resp_valid), 32'h0);
    end
    step();
    rif.req_valid = 4'b1111;
    rif.req_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("t6_restart", 32'(rif.req_ready), 32'h1);
    step();
    rif.req_valid = '0;
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
